// File: rtl/alu_mul_if.sv
// Execute-stage ALU bus: control code, operands and launch request in;
// result, flags, stall, HI and multiply-complete pulse out.
interface alu_mul_if #(
    parameter int DATA_W = 32
);
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] alu_in_0;
    logic [DATA_W-1:0] alu_in_1;
    logic [4:0]        shamt;
    logic              start;
    logic [DATA_W-1:0] alu_out;
    logic              zero_flag;
    logic              overflow;
    logic              stall;
    logic [DATA_W-1:0] mul_hi;
    logic              mul_done;
    logic [1:0]        fsm_state;

    // Handshake: start qualifies a MULT launch in IDLE; stall stays high from
    // the launch cycle through DONE, and mul_done pulses once when HI/LO load.
    modport master (
        output alu_control, alu_in_0, alu_in_1, shamt, start,
        input  alu_out, zero_flag, overflow, stall, mul_hi, mul_done, fsm_state
    );

    modport slave (
        input  alu_control, alu_in_0, alu_in_1, shamt, start,
        output alu_out, zero_flag, overflow, stall, mul_hi, mul_done, fsm_state
    );
endinterface

// File: rtl/alu_mul.sv
// Execute-stage ALU with combinational ops and an iterative shift-add MULT into HI/LO.
// Define ALU_MUL_SIGNED_EN for a signed multiply (magnitude operands + sign fixup).
module alu_mul #(
    parameter int DATA_W = 32
) (
    input logic       clk,
    input logic       arst,
    alu_mul_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_MULT = 4'd13;

    state_t              state_q;
    logic [DATA_W-1:0]   mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;
    logic [2*DATA_W-1:0] product_d;
    logic [DATA_W:0]     add_sum;
    logic [4:0]          cnt_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                mul_done_q;
    logic                launch;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
`ifdef ALU_MUL_SIGNED_EN
    logic                neg_q;
`endif

    assign launch = bus.start && (bus.alu_control == OP_MULT);

`ifdef ALU_MUL_SIGNED_EN
    assign a_mag     = bus.alu_in_0[DATA_W-1] ? -bus.alu_in_0 : bus.alu_in_0;
    assign b_mag     = bus.alu_in_1[DATA_W-1] ? -bus.alu_in_1 : bus.alu_in_1;
    assign product_d = neg_q ? (~acc_q + 1'b1) : acc_q;
`else
    assign a_mag     = bus.alu_in_0;
    assign b_mag     = bus.alu_in_1;
    assign product_d = acc_q;
`endif

    // The 65-bit {carry, acc} shift keeps the add carry in the top product bit.
    always_comb begin
        add_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                + (mplier_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
        acc_d   = {add_sum, acc_q[DATA_W-1:1]};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mul_done_q <= 1'b0;
`ifdef ALU_MUL_SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            mul_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        acc_q    <= '0;
                        cnt_q    <= '0;
`ifdef ALU_MUL_SIGNED_EN
                        neg_q    <= bus.alu_in_0[DATA_W-1] ^ bus.alu_in_1[DATA_W-1];
`endif
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'(DATA_W-1)) begin
                        state_q    <= DONE;
                        mul_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    hi_q    <= product_d[2*DATA_W-1:DATA_W];
                    lo_q    <= product_d[DATA_W-1:0];
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] sum_res;
    logic [DATA_W-1:0] diff_res;
    logic [DATA_W-1:0] result;
    logic              ovf;

    assign sum_res  = bus.alu_in_0 + bus.alu_in_1;
    assign diff_res = bus.alu_in_0 - bus.alu_in_1;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (bus.alu_control)
            OP_AND:  result = bus.alu_in_0 & bus.alu_in_1;
            OP_OR:   result = bus.alu_in_0 | bus.alu_in_1;
            OP_ADD: begin
                result = sum_res;
                ovf    = (bus.alu_in_0[DATA_W-1] == bus.alu_in_1[DATA_W-1])
                      && (sum_res[DATA_W-1] != bus.alu_in_0[DATA_W-1]);
            end
            OP_SLL:  result = bus.alu_in_1 << bus.shamt;
            OP_SRL:  result = bus.alu_in_1 >> bus.shamt;
            OP_SUB: begin
                result = diff_res;
                ovf    = (bus.alu_in_0[DATA_W-1] != bus.alu_in_1[DATA_W-1])
                      && (diff_res[DATA_W-1] != bus.alu_in_0[DATA_W-1]);
            end
            OP_SLT:  result = {{(DATA_W-1){1'b0}},
                               ($signed(bus.alu_in_0) < $signed(bus.alu_in_1))};
            OP_NOR:  result = ~(bus.alu_in_0 | bus.alu_in_1);
            OP_MULT: result = lo_q;
            default: result = '0;
        endcase
    end

    assign bus.alu_out   = result;
    assign bus.zero_flag = (result == '0);
    assign bus.overflow  = ovf;
    assign bus.mul_hi    = hi_q;
    assign bus.mul_done  = mul_done_q;
    assign bus.fsm_state = state_q;
    // Gated by arst so the hold request drops the moment reset asserts.
    assign bus.stall     = !arst && ((state_q != IDLE) || launch);
endmodule

// File: tb/tb_alu_mul.sv
// Directed bench for alu_mul: combinational ops, MULT latency/stall window,
// operand isolation during BUSY and asynchronous reset mid-multiply.
module tb_alu_mul;
    logic clk;
    logic arst;
    int   checks;
    int   errors;
    int   stall_n;
    int   done_at;
    int   done_n;

    alu_mul_if #(.DATA_W(32)) bus ();

    alu_mul #(.DATA_W(32)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
        @(negedge clk);
        bus.alu_control = op;
        bus.alu_in_0    = a;
        bus.alu_in_1    = b;
        bus.shamt       = sh;
        bus.start       = 1'b1;
        #1;
    endtask

    // c=1 is the launch cycle; DONE is expected at c=34. start drops after mul_done.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int disturb_c,
                            output int s_n, output int d_at, output int d_n);
        @(negedge clk);
        bus.alu_control = 4'd13;
        bus.alu_in_0    = a;
        bus.alu_in_1    = b;
        bus.start       = 1'b1;
        s_n  = 0;
        d_at = 0;
        d_n  = 0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (bus.stall) s_n++;
            if (bus.mul_done) begin
                d_n++;
                d_at = c;
            end
            if (c == disturb_c) begin
                bus.alu_in_0 = '0;
                bus.alu_in_1 = '0;
            end
            @(negedge clk);
            if (d_n > 0) bus.start = 1'b0;
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        arst            = 1'b1;
        bus.alu_control = 4'd13;
        bus.alu_in_0    = '0;
        bus.alu_in_1    = '0;
        bus.shamt       = '0;
        bus.start       = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_alu_out",  64'(bus.alu_out), 64'h0);
        check("rst_mul_hi",   64'(bus.mul_hi), 64'h0);
        check("rst_stall",    64'(bus.stall), 64'h0);
        check("rst_mul_done", 64'(bus.mul_done), 64'h0);
        check("rst_state",    64'(bus.fsm_state), 64'h0);

        set_op(4'd2, 32'h7FFF_FFFF, 32'h1, 5'd0);
        check("add_out", 64'(bus.alu_out), 64'h8000_0000);
        check("add_ovf", 64'(bus.overflow), 64'h1);
        set_op(4'd5, 32'd5, 32'd5, 5'd0);
        check("sub_out",  64'(bus.alu_out), 64'h0);
        check("sub_zero", 64'(bus.zero_flag), 64'h1);
        check("sub_ovf",  64'(bus.overflow), 64'h0);
        set_op(4'd5, 32'h8000_0000, 32'h1, 5'd0);
        check("sub_ovf_neg", 64'(bus.overflow), 64'h1);
        set_op(4'd7, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check("slt_out", 64'(bus.alu_out), 64'h1);
        set_op(4'd3, 32'h0, 32'h1, 5'd31);
        check("sll_out", 64'(bus.alu_out), 64'h8000_0000);
        set_op(4'd4, 32'h0, 32'h8000_0000, 5'd4);
        check("srl_out", 64'(bus.alu_out), 64'h0800_0000);
        set_op(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        check("and_out", 64'(bus.alu_out), 64'hF000_F000);
        check("and_stall", 64'(bus.stall), 64'h0);
        set_op(4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        check("or_out", 64'(bus.alu_out), 64'hFFF0_FFF0);
        set_op(4'd12, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        check("nor_out", 64'(bus.alu_out), 64'h000F_000F);
        set_op(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        check("undef_out",  64'(bus.alu_out), 64'h0);
        check("undef_zero", 64'(bus.zero_flag), 64'h1);
        bus.start = 1'b0;

        run_mult(32'h0001_0000, 32'h0001_0000, 0, stall_n, done_at, done_n);
        check("m1_stall_cycles", 64'(stall_n), 64'd34);
        check("m1_done_at",      64'(done_at), 64'd34);
        check("m1_done_count",   64'(done_n), 64'd1);
        check("m1_hi",           64'(bus.mul_hi), 64'h1);
        check("m1_lo",           64'(bus.alu_out), 64'h0);
        check("m1_zero",         64'(bus.zero_flag), 64'h1);
        check("m1_stall_after",  64'(bus.stall), 64'h0);

`ifdef ALU_MUL_SIGNED_EN
        run_mult(32'hFFFF_FFFD, 32'd7, 0, stall_n, done_at, done_n);
        check("m2_stall_cycles", 64'(stall_n), 64'd34);
        check("m2_hi", 64'(bus.mul_hi), 64'hFFFF_FFFF);
        check("m2_lo", 64'(bus.alu_out), 64'hFFFF_FFEB);
`else
        run_mult(32'hFFFF_FFFF, 32'd2, 0, stall_n, done_at, done_n);
        check("m2_stall_cycles", 64'(stall_n), 64'd34);
        check("m2_hi", 64'(bus.mul_hi), 64'h1);
        check("m2_lo", 64'(bus.alu_out), 64'hFFFF_FFFE);
`endif

        run_mult(32'h0, 32'hDEAD_BEEF, 0, stall_n, done_at, done_n);
        check("m3_hi", 64'(bus.mul_hi), 64'h0);
        check("m3_lo", 64'(bus.alu_out), 64'h0);

        // Operands cleared at BUSY cycle 10 (c=11) must not affect the latched multiply.
        run_mult(32'h1234_5678, 32'h0000_0100, 11, stall_n, done_at, done_n);
        check("m4_done_at", 64'(done_at), 64'd34);
        check("m4_hi", 64'(bus.mul_hi), 64'h12);
        check("m4_lo", 64'(bus.alu_out), 64'h3456_7800);

        @(negedge clk);
        bus.alu_control = 4'd13;
        bus.alu_in_0    = 32'h0001_0000;
        bus.alu_in_1    = 32'h0001_0000;
        bus.start       = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check("rb_busy_state", 64'(bus.fsm_state), 64'h1);
        arst      = 1'b1;
        bus.start = 1'b0;
        #1;
        check("rb_stall", 64'(bus.stall), 64'h0);
        check("rb_hi",    64'(bus.mul_hi), 64'h0);
        check("rb_lo",    64'(bus.alu_out), 64'h0);
        check("rb_state", 64'(bus.fsm_state), 64'h0);
        @(negedge clk);
        arst   = 1'b0;
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus.mul_done) done_n++;
        end
        check("rb_no_done", 64'(done_n), 64'd0);

        run_mult(32'd3, 32'd5, 0, stall_n, done_at, done_n);
        check("m5_stall_cycles", 64'(stall_n), 64'd34);
        check("m5_done_at",      64'(done_at), 64'd34);
        check("m5_hi", 64'(bus.mul_hi), 64'h0);
        check("m5_lo", 64'(bus.alu_out), 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mul.md
# alu_mul

Execute-stage ALU consuming the 4-bit ALU control code and the two operands, with an iterative 32×32 multiplier for MULT. Non-multiply operations resolve combinationally in the same cycle. MULT runs a shift-add sequence over multiple cycles, holds `stall` high to freeze the pipeline, and writes a 64-bit product into internal HI/LO registers.

## Interface
- `DATA_W`, 32: operand and result width; the multiplier and shift amounts assume 32.
- `clk`  in  1  single clock, rising edge.
- `arst`  in  1  asynchronous, active-high reset.
- `alu_control`  in  4  operation code: AND=0, OR=1, ADD=2, SLL=3, SRL=4, SUB=5, SLT=7, NOR=12, MULT=13; all others produce 0.
- `alu_in_0`  in  DATA_W  operand A (rs).
- `alu_in_1`  in  DATA_W  operand B (rt).
- `shamt`  in  5  shift amount for SLL/SRL; shifts operand B.
- `start`  in  1  instruction valid in execute; qualifies MULT launch.
- `alu_out`  out  DATA_W  result; for MULT, the LO register.
- `zero_flag`  out  1  `alu_out == 0`.
- `overflow`  out  1  signed overflow for ADD/SUB, 0 otherwise.
- `stall`  out  1  pipeline hold request.
- `mul_hi`  out  DATA_W  HI register.
- `mul_done`  out  1  one-cycle pulse when HI/LO are updated.

## Operation
- Combinational ops:
  - AND, OR, NOR, ADD, SUB per code.
  - SLT: signed compare, result 1 or 0.
  - SLL/SRL: logical shift of `alu_in_1` by `shamt`.
- Overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - When `start && alu_control==13`: latch A and B, clear the accumulator, set counter to 0, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Each cycle: if multiplier LSB is 1, add multiplicand to the upper accumulator half; shift the 65-bit {carry, acc} right by 1; increment counter.
  - When the counter reaches 31, go to DONE.
- DONE:
  - Apply the sign fixup (see Configuration).
  - Write HI/LO, pulse `mul_done`, return to IDLE.
- `stall` = (state != IDLE) | (state==IDLE & start & alu_control==13). It is combinational and asserts in the launch cycle.
- Operands and `alu_control` changes during BUSY/DONE do not affect the multiply in flight.
- `start` during BUSY/DONE is ignored. The pipeline is stalled, so it holds the same MULT instruction.
- In the cycle after DONE, `stall` is low if `start` is deasserted or the code is not MULT.
  - The frozen MULT instruction in execute must advance in that cycle.
  - The control path drops `start` for that instruction after `mul_done`. The block does not relaunch on `start` in the cycle where `mul_done` was high.
- Product of 0 or of any operand 0: HI=LO=0.

## Timing
- Reset values: state IDLE, HI=0, LO=0, counter=0, `mul_done`=0, `stall`=0 (with `start` low).
- With `alu_control==13` after reset, `alu_out` = 0.
- Combinational ops: 0-cycle latency; `alu_out`, `zero_flag` and `overflow` are valid in the same cycle.
- MULT launch at edge N (IDLE→BUSY):
  - BUSY spans 32 cycles.
  - DONE is the cycle after edge N+32; `mul_done` is high in that cycle.
  - HI/LO update at edge N+33.
  - `stall` is high from the launch cycle through the DONE cycle: 34 cycles total.
- `alu_out` for MULT shows the new LO from edge N+33.
- Reset asserted mid-BUSY: state goes immediately to IDLE; HI/LO/counter go to 0; `stall` drops asynchronously; no `mul_done`.

## Configuration
- `ALU_MUL_SIGNED_EN` defined:
  - Operands are converted to magnitude at latch time.
  - In DONE, the 64-bit product is two's-complement negated if A[31]^B[31].
  - Latency is unchanged.
- Not defined:
  - Unsigned multiply; no fixup logic.
  - 0xFFFFFFFF×2 gives HI=1, LO=0xFFFFFFFE.

## Test plan
- Reset released, `alu_control`=13, `start`=0 → `alu_out`=0, `mul_hi`=0, `stall`=0, `mul_done`=0.
- ADD 0x7FFFFFFF+1 → `alu_out`=0x80000000, `overflow`=1. SUB 5-5 → 0, `zero_flag`=1. SLT -1<1 → 1. SLL 1 by 31 → 0x80000000.
- MULT 0x00010000×0x00010000, `start` held → `stall` high for 34 cycles, `mul_done` in the 34th, then HI=1, LO=0.
- Signed build, MULT -3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Unsigned build, 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE.
- MULT launched, operands changed to 0 at cycle 10 of BUSY → result still the product of the latched operands.
- `arst` pulsed at BUSY cycle 15 → `stall`=0 immediately, HI=LO=0, no `mul_done`. A fresh MULT afterwards gives the correct product with 34-cycle latency.
